la_dump_uart: RTL and testbench

Post-capture readout engine for the logic analyzer. Once a capture completes, it reads the circular sample buffer from the oldest sample to the newest. It frames the samples with a header carrying the trigger index and shifts the frame out on a UART TX line to the host. It sits between the capture RAM read port and the board UART pin, and is started by the capture-done pulse in `fpga_top`.

---
 rtl/la_pkg.sv | 35 +++
 rtl/la_uart_tx_byte.sv | 54 +++++
 rtl/la_dump_uart.sv | 157 +++++++++++++++
 tb/tb_la_dump_uart.sv | 332 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/la_pkg.sv
// Shared definitions for the logic-analyzer readout path: frame sync bytes,
// the dump FSM state encoding, the sample type and the header byte selector.
package la_pkg;

  localparam logic [7:0] LA_SYNC0  = 8'hA5;
  localparam logic [7:0] LA_SYNC1  = 8'h5A;
  localparam int         LA_DATA_W = 8;

  typedef logic [LA_DATA_W-1:0] la_sample_t;

  // DRAIN lets an in-flight byte finish after an abort before going idle.
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HDR,
    ST_RD_REQ,
    ST_RD_WAIT,
    ST_SEND,
    ST_TRAILER,
    ST_DONE,
    ST_DRAIN
  } la_state_t;

  // Header byte n of the frame; trig is the trigger index zero-extended to 16 bits.
  function automatic logic [7:0] la_hdr_byte(input logic [1:0] idx, input logic [15:0] trig);
    logic [7:0] b;
    case (idx)
      2'd0:    b = LA_SYNC0;
      2'd1:    b = LA_SYNC1;
      2'd2:    b = trig[15:8];
      default: b = trig[7:0];
    endcase
    return b;
  endfunction

endpackage

// File: rtl/la_uart_tx_byte.sv
// 8N1 UART byte serializer. tx_ready is high when idle or during the final
// cycle of the stop bit, so a byte offered then follows with no idle gap.
module la_uart_tx_byte #(
  parameter int BAUD_DIV = 434
) (
  input  logic       sys_clk,
  input  logic       sys_rst_n,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       txd
);

  localparam int CW = $clog2(BAUD_DIV);

  logic [CW-1:0] baud_cnt_reg;
  logic [9:0]    shift_reg;
  logic [3:0]    bit_cnt_reg;
  logic          active_reg;
  logic          bit_end;

  assign bit_end  = (baud_cnt_reg == CW'(BAUD_DIV - 1));
  assign tx_ready = !active_reg || (bit_end && (bit_cnt_reg == 4'd9));
  // Idle line is driven high straight from reset state, so reset forces it high at once.
  assign txd      = active_reg ? shift_reg[0] : 1'b1;

  // Load a framed byte on handshake, otherwise step bit timing and shift.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      baud_cnt_reg <= '0;
      shift_reg    <= '1;
      bit_cnt_reg  <= '0;
      active_reg   <= 1'b0;
    end else if (tx_valid && tx_ready) begin
      shift_reg    <= {1'b1, tx_data, 1'b0};
      baud_cnt_reg <= '0;
      bit_cnt_reg  <= '0;
      active_reg   <= 1'b1;
    end else if (active_reg) begin
      if (bit_end) begin
        baud_cnt_reg <= '0;
        if (bit_cnt_reg == 4'd9) begin
          active_reg <= 1'b0;
        end else begin
          bit_cnt_reg <= bit_cnt_reg + 4'd1;
          shift_reg   <= {1'b1, shift_reg[9:1]};
        end
      end else begin
        baud_cnt_reg <= baud_cnt_reg + CW'(1);
      end
    end
  end

endmodule

// File: rtl/la_dump_uart.sv
// Capture buffer readout: sends sync + trigger index header, then every sample
// from oldest to newest over UART. Optional XOR checksum trailer is compiled in
// with LA_DUMP_CHECKSUM_EN.
module la_dump_uart
  import la_pkg::*;
#(
  parameter int CLK_FREQ = 50_000_000,
  parameter int BAUD     = 115200,
  parameter int ADDR_W   = 11,
  parameter int DATA_W   = 8
) (
  input  logic              sys_clk,
  input  logic              sys_rst_n,
  input  logic              start,
  input  logic              abort,
  input  logic [ADDR_W-1:0] rd_start_addr,
  input  logic [ADDR_W-1:0] trigger_index,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_rd_addr,
  input  logic [DATA_W-1:0] mem_rd_data,
  output logic              uart_txd,
  output logic              busy,
  output logic              dump_done
);

  localparam int              BAUD_DIV = CLK_FREQ / BAUD;
  localparam logic [ADDR_W:0] LAST_CNT = {1'b0, {ADDR_W{1'b1}}};

  la_state_t         state_reg, state_next;
  logic [1:0]        hdr_idx_reg;
  logic [ADDR_W-1:0] addr_reg;
  logic [ADDR_W:0]   cnt_reg;
  logic [ADDR_W-1:0] trig_reg;
  la_sample_t        sample_reg;
  logic [15:0]       trig16;
  logic [7:0]        tx_data;
  logic              tx_valid;
  logic              tx_ready;

`ifdef LA_DUMP_CHECKSUM_EN
  logic [7:0] cksum_reg;
  logic       ck_sent_reg;
`endif

  assign trig16      = 16'(trig_reg);
  assign mem_rd_en   = (state_reg == ST_RD_REQ);
  assign mem_rd_addr = addr_reg;
  assign busy        = (state_reg != ST_IDLE) && (state_reg != ST_DONE);
  assign dump_done   = (state_reg == ST_DONE);

  // State register.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) state_reg <= ST_IDLE;
    else            state_reg <= state_next;
  end

  // Next-state and serializer handshake; abort stops new bytes and drains.
  always_comb begin
    state_next = state_reg;
    tx_valid   = 1'b0;
    tx_data    = sample_reg;
    case (state_reg)
      ST_IDLE: if (start && !abort) state_next = ST_HDR;
      ST_HDR: begin
        if (abort) begin
          state_next = ST_DRAIN;
        end else begin
          tx_valid = 1'b1;
          tx_data  = la_hdr_byte(hdr_idx_reg, trig16);
          if (tx_ready && (hdr_idx_reg == 2'd3)) state_next = ST_RD_REQ;
        end
      end
      ST_RD_REQ:  state_next = abort ? ST_DRAIN : ST_RD_WAIT;
      ST_RD_WAIT: state_next = abort ? ST_DRAIN : ST_SEND;
      ST_SEND: begin
        if (abort) begin
          state_next = ST_DRAIN;
        end else begin
          tx_valid = 1'b1;
          if (tx_ready) state_next = (cnt_reg == LAST_CNT) ? ST_TRAILER : ST_RD_REQ;
        end
      end
      ST_TRAILER: begin
        if (abort) begin
          state_next = ST_DRAIN;
        end else begin
`ifdef LA_DUMP_CHECKSUM_EN
          if (!ck_sent_reg) begin
            tx_valid = 1'b1;
            tx_data  = cksum_reg;
          end else if (tx_ready) begin
            state_next = ST_DONE;
          end
`else
          if (tx_ready) state_next = ST_DONE;
`endif
        end
      end
      ST_DONE:  state_next = ST_IDLE;
      ST_DRAIN: if (tx_ready) state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
  end

  // Frame context: latch on start, advance header index, address and sample count.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      hdr_idx_reg <= '0;
      addr_reg    <= '0;
      cnt_reg     <= '0;
      trig_reg    <= '0;
      sample_reg  <= '0;
    end else begin
      if (state_reg == ST_IDLE && state_next == ST_HDR) begin
        addr_reg    <= rd_start_addr;
        trig_reg    <= trigger_index;
        cnt_reg     <= '0;
        hdr_idx_reg <= '0;
      end
      if (state_reg == ST_HDR && tx_valid && tx_ready) hdr_idx_reg <= hdr_idx_reg + 2'd1;
      if (state_reg == ST_RD_WAIT && state_next == ST_SEND) sample_reg <= la_sample_t'(mem_rd_data);
      if (state_reg == ST_SEND && tx_valid && tx_ready) begin
        cnt_reg <= cnt_reg + 1'b1;
        // Address wraps naturally at the buffer depth.
        if (cnt_reg != LAST_CNT) addr_reg <= addr_reg + 1'b1;
      end
    end
  end

`ifdef LA_DUMP_CHECKSUM_EN
  // XOR of every sample read this frame; trailer-sent flag.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      cksum_reg   <= '0;
      ck_sent_reg <= 1'b0;
    end else if (state_reg == ST_IDLE && state_next == ST_HDR) begin
      cksum_reg   <= '0;
      ck_sent_reg <= 1'b0;
    end else begin
      if (state_reg == ST_RD_WAIT && state_next == ST_SEND) cksum_reg <= cksum_reg ^ mem_rd_data[7:0];
      if (state_reg == ST_TRAILER && tx_valid && tx_ready) ck_sent_reg <= 1'b1;
    end
  end
`endif

  la_uart_tx_byte #(
    .BAUD_DIV (BAUD_DIV)
  ) u_tx (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .tx_data   (tx_data),
    .tx_valid  (tx_valid),
    .tx_ready  (tx_ready),
    .txd       (uart_txd)
  );

endmodule

// File: tb/tb_la_dump_uart.sv
// Bench for la_dump_uart: RAM model, UART monitor with byte scoreboard,
// table of full-frame scenarios, plus abort / reset / blocked-start sequences.
module tb_la_dump_uart;

  localparam int CLK_FREQ = 50_000_000;
  localparam int BAUD     = 12_500_000;
  localparam int DIV      = CLK_FREQ / BAUD;
  localparam int ADDR_W   = 9;
  localparam int DEPTH    = 1 << ADDR_W;
`ifdef LA_DUMP_CHECKSUM_EN
  localparam int CK = 1;
`else
  localparam int CK = 0;
`endif
  localparam int FRAME_BYTES = 4 + DEPTH + CK;
  localparam int FRAME_CYC   = FRAME_BYTES * 10 * DIV;

  logic              sys_clk = 1'b0;
  logic              sys_rst_n = 1'b0;
  logic              start = 1'b0;
  logic              abort = 1'b0;
  logic [ADDR_W-1:0] rd_start_addr = '0;
  logic [ADDR_W-1:0] trigger_index = '0;
  logic              mem_rd_en;
  logic [ADDR_W-1:0] mem_rd_addr;
  logic [7:0]        mem_rd_data;
  logic              uart_txd;
  logic              busy;
  logic              dump_done;

  la_dump_uart #(
    .CLK_FREQ (CLK_FREQ),
    .BAUD     (BAUD),
    .ADDR_W   (ADDR_W),
    .DATA_W   (8)
  ) dut (
    .sys_clk       (sys_clk),
    .sys_rst_n     (sys_rst_n),
    .start         (start),
    .abort         (abort),
    .rd_start_addr (rd_start_addr),
    .trigger_index (trigger_index),
    .mem_rd_en     (mem_rd_en),
    .mem_rd_addr   (mem_rd_addr),
    .mem_rd_data   (mem_rd_data),
    .uart_txd      (uart_txd),
    .busy          (busy),
    .dump_done     (dump_done)
  );

  always #5 sys_clk = ~sys_clk;

  int tests = 0;
  int fails = 0;

  // Free-running cycle count, RAM model, read log and done-pulse count.
  int         cyc = 0;
  logic [7:0] ram [DEPTH];
  int         rd_cnt = 0;
  int         rd_log [4096];
  int         done_cnt = 0;

  always @(posedge sys_clk) cyc <= cyc + 1;

  always @(posedge sys_clk) begin
    if (mem_rd_en) begin
      mem_rd_data             <= ram[mem_rd_addr];
      rd_log[rd_cnt % 4096]   <= int'(mem_rd_addr);
      rd_cnt                  <= rd_cnt + 1;
    end
  end

  always @(posedge sys_clk) if (dump_done === 1'b1) done_cnt <= done_cnt + 1;

  // Scoreboard and monitor bookkeeping.
  logic [7:0] exp_q [$];
  int mon_starts = 0;
  int last_start = 0;
  int frame_base = 0;
  int rst_cyc    = -1;
  int start_log [8192];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Decodes uart_txd at mid-bit on falling clock edges; bytes cut by reset are dropped.
  task automatic monitor_loop();
    int         st;
    logic [9:0] bits;
    forever begin
      @(negedge sys_clk);
      if (sys_rst_n === 1'b1 && uart_txd === 1'b0) begin
        st = cyc;
        if (mon_starts > frame_base) check("byte_gap", 64'(st - last_start), 64'(10 * DIV));
        last_start = st;
        start_log[mon_starts % 8192] = st;
        mon_starts++;
        repeat (DIV / 2) @(negedge sys_clk);
        bits[0] = uart_txd;
        for (int k = 1; k < 10; k++) begin
          repeat (DIV) @(negedge sys_clk);
          bits[k] = uart_txd;
        end
        if (rst_cyc < st) begin
          check("start_bit", 64'(bits[0]), 64'(0));
          check("stop_bit", 64'(bits[9]), 64'(1));
          if (exp_q.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL unexpected_byte: got 0x%0h expected none", bits[8:1]);
          end else begin
            check("frame_byte", 64'(bits[8:1]), 64'(exp_q.pop_front()));
          end
        end
      end
    end
  endtask

  typedef struct {
    logic [ADDR_W-1:0] start_addr;
    logic [ADDR_W-1:0] trig;
    int                pattern;     // 0: ram[i]=i[7:0]; 1: ram[start]=FF, rest 0
    bit                dbl_start;   // extra start pulse at byte 10
    bit                pre_reset;   // reset mid-bit of a frame before this one
    logic [7:0]        exp_hdr2;
    logic [7:0]        exp_hdr3;
    int                exp_rd0, exp_rd1, exp_rd2, exp_rd_last;
    logic [7:0]        exp_cksum;
  } vec_t;

  vec_t vecs [3];

  task automatic fill_ram(input int pattern, input int saddr);
    for (int i = 0; i < DEPTH; i++) ram[i] = (pattern == 0) ? 8'(i) : 8'h00;
    if (pattern == 1) ram[saddr] = 8'hFF;
  endtask

  task automatic pulse_start(input logic [ADDR_W-1:0] sa, input logic [ADDR_W-1:0] ti, output int t0);
    @(negedge sys_clk);
    rd_start_addr = sa;
    trigger_index = ti;
    start         = 1'b1;
    @(negedge sys_clk);
    start = 1'b0;
    t0    = cyc;
  endtask

  // Reset asserted during a 0 data bit of the first header byte; nothing may resume.
  task automatic reset_mid_frame();
    int t0;
    int c;
    frame_base = mon_starts;
    pulse_start('0, '0, t0);
    c = 0;
    while (mon_starts - frame_base < 1 && c < 50) begin
      @(negedge sys_clk);
      c++;
    end
    check("rst_wait_start_bit", 64'(mon_starts - frame_base), 64'(1));
    repeat (2 * DIV) @(negedge sys_clk);
    check("rst_pre_txd_low", 64'(uart_txd), 64'(0));
    sys_rst_n = 1'b0;
    rst_cyc   = cyc;
    #1;
    check("rst_txd", 64'(uart_txd), 64'(1));
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_done", 64'(dump_done), 64'(0));
    check("rst_rd_en", 64'(mem_rd_en), 64'(0));
    check("rst_rd_addr", 64'(mem_rd_addr), 64'(0));
    repeat (3) @(negedge sys_clk);
    sys_rst_n = 1'b1;
    repeat (12 * DIV) @(negedge sys_clk);
    check("rst_no_resume_busy", 64'(busy), 64'(0));
    check("rst_no_resume_bytes", 64'(mon_starts - frame_base), 64'(1));
    $display("[TB] reset mid-frame sequence complete");
  endtask

  task automatic run_frame(input int v);
    int t0, t_done, rd_base, done_base, idle_starts;
    bit found, pulse, dbl_done;
    logic busy_at_done;
    fill_ram(vecs[v].pattern, int'(vecs[v].start_addr));
    if (vecs[v].pre_reset) reset_mid_frame();
    frame_base = mon_starts;
    rd_base    = rd_cnt;
    done_base  = done_cnt;
    exp_q.push_back(8'hA5);
    exp_q.push_back(8'h5A);
    exp_q.push_back(vecs[v].exp_hdr2);
    exp_q.push_back(vecs[v].exp_hdr3);
    for (int i = 0; i < DEPTH; i++) exp_q.push_back(ram[(int'(vecs[v].start_addr) + i) % DEPTH]);
    if (CK == 1) exp_q.push_back(vecs[v].exp_cksum);
    pulse_start(vecs[v].start_addr, vecs[v].trig, t0);
    check("busy_after_start", 64'(busy), 64'(1));
    found = 0; pulse = 0; dbl_done = 0; t_done = 0; busy_at_done = 1'b1;
    for (int c = 0; c < FRAME_CYC + 100 && !found; c++) begin
      @(negedge sys_clk);
      if (pulse) begin
        start = 1'b0;
        pulse = 0;
      end
      if (dump_done === 1'b1) begin
        found        = 1;
        t_done       = cyc;
        busy_at_done = busy;
      end else if (vecs[v].dbl_start && !dbl_done && (mon_starts - frame_base) >= 10) begin
        rd_start_addr = vecs[v].start_addr ^ 9'h100;
        start         = 1'b1;
        pulse         = 1;
        dbl_done      = 1;
      end
    end
    start = 1'b0;
    check("done_seen", 64'(found), 64'(1));
    tests++;
    if (!found || t_done - t0 < FRAME_CYC + 1 - 2 || t_done - t0 > FRAME_CYC + 1 + 2) begin
      fails++;
      $display("FAIL frame_len: got %0d cycles expected %0d +-2", t_done - t0, FRAME_CYC + 1);
    end
    check("busy_at_done", 64'(busy_at_done), 64'(0));
    tests++;
    if (start_log[frame_base % 8192] - t0 > 2) begin
      fails++;
      $display("FAIL first_start_bit_latency: got %0d cycles expected <= 2", start_log[frame_base % 8192] - t0);
    end
    idle_starts = mon_starts;
    repeat (15 * DIV) @(negedge sys_clk);
    check("bytes_left", 64'(exp_q.size()), 64'(0));
    check("done_pulses", 64'(done_cnt - done_base), 64'(1));
    check("idle_after_frame", 64'(mon_starts - idle_starts), 64'(0));
    check("rd_count", 64'(rd_cnt - rd_base), 64'(DEPTH));
    check("rd_first0", 64'(rd_log[rd_base % 4096]), 64'(vecs[v].exp_rd0));
    check("rd_first1", 64'(rd_log[(rd_base + 1) % 4096]), 64'(vecs[v].exp_rd1));
    check("rd_first2", 64'(rd_log[(rd_base + 2) % 4096]), 64'(vecs[v].exp_rd2));
    check("rd_last", 64'(rd_log[(rd_cnt - 1) % 4096]), 64'(vecs[v].exp_rd_last));
    $display("[TB] frame %0d: start=0x%0h trig=0x%0h bytes=%0d len=%0d cycles", v,
             vecs[v].start_addr, vecs[v].trig, mon_starts - frame_base, t_done - t0);
  endtask

  // Abort during the start bit of sample byte 5 (frame byte 9).
  task automatic abort_sequence();
    int t0, c, done_base, idle_starts, high_err;
    fill_ram(0, 0);
    frame_base = mon_starts;
    done_base  = done_cnt;
    exp_q.push_back(8'hA5);
    exp_q.push_back(8'h5A);
    exp_q.push_back(8'h00);
    exp_q.push_back(8'h42);
    for (int i = 0; i < 6; i++) exp_q.push_back(8'(i));
    pulse_start('0, 9'h042, t0);
    c = 0;
    while (mon_starts - frame_base < 10 && c < 20 * 10 * DIV) begin
      @(negedge sys_clk);
      c++;
    end
    check("abort_reach_byte9", 64'(mon_starts - frame_base), 64'(10));
    @(negedge sys_clk);
    abort = 1'b1;
    c = 0;
    while (busy === 1'b1 && c < 15 * DIV) begin
      @(negedge sys_clk);
      c++;
    end
    check("abort_busy_fall", 64'(busy), 64'(0));
    abort       = 1'b0;
    idle_starts = mon_starts;
    high_err    = 0;
    for (int k = 0; k < 30 * DIV; k++) begin
      @(negedge sys_clk);
      if (uart_txd !== 1'b1) high_err++;
    end
    check("abort_txd_idle", 64'(high_err), 64'(0));
    check("abort_no_new_byte", 64'(mon_starts - idle_starts), 64'(0));
    check("abort_bytes_sent", 64'(mon_starts - frame_base), 64'(10));
    check("abort_bytes_left", 64'(exp_q.size()), 64'(0));
    check("abort_no_done", 64'(done_cnt - done_base), 64'(0));
    $display("[TB] abort sequence: %0d bytes sent", mon_starts - frame_base);
  endtask

  // abort held in IDLE must block start.
  task automatic blocked_start_sequence();
    int t0, s0;
    s0 = mon_starts;
    abort = 1'b1;
    pulse_start('0, '0, t0);
    repeat (5 * DIV) @(negedge sys_clk);
    check("blocked_start_busy", 64'(busy), 64'(0));
    check("blocked_start_bytes", 64'(mon_starts - s0), 64'(0));
    abort = 1'b0;
    $display("[TB] start with abort held: ignored");
  endtask

  initial begin
    vecs[0] = '{start_addr: 9'h000, trig: 9'h123, pattern: 0, dbl_start: 1'b1, pre_reset: 1'b0,
                exp_hdr2: 8'h01, exp_hdr3: 8'h23, exp_rd0: 'h000, exp_rd1: 'h001, exp_rd2: 'h002,
                exp_rd_last: 'h1FF, exp_cksum: 8'h00};
    vecs[1] = '{start_addr: 9'h1FE, trig: 9'h00A, pattern: 1, dbl_start: 1'b0, pre_reset: 1'b0,
                exp_hdr2: 8'h00, exp_hdr3: 8'h0A, exp_rd0: 'h1FE, exp_rd1: 'h1FF, exp_rd2: 'h000,
                exp_rd_last: 'h1FD, exp_cksum: 8'hFF};
    vecs[2] = '{start_addr: 9'h055, trig: 9'h1AB, pattern: 0, dbl_start: 1'b0, pre_reset: 1'b1,
                exp_hdr2: 8'h01, exp_hdr3: 8'hAB, exp_rd0: 'h055, exp_rd1: 'h056, exp_rd2: 'h057,
                exp_rd_last: 'h054, exp_cksum: 8'h00};

    fill_ram(0, 0);
    repeat (3) @(negedge sys_clk);
    check("reset_txd", 64'(uart_txd), 64'(1));
    check("reset_busy", 64'(busy), 64'(0));
    check("reset_done", 64'(dump_done), 64'(0));
    check("reset_rd_en", 64'(mem_rd_en), 64'(0));
    check("reset_rd_addr", 64'(mem_rd_addr), 64'(0));
    sys_rst_n = 1'b1;
    fork
      monitor_loop();
    join_none
    repeat (3) @(negedge sys_clk);

    blocked_start_sequence();
    for (int v = 0; v < 3; v++) run_frame(v);
    abort_sequence();

    repeat (10) @(negedge sys_clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
